stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEB_SAMPLES, default 3, meaning the number of consecutive equal filter-strobe samples needed to accept a button level (range 2..15).
REQ-002 SHALL have parameter WRAP_EN, default 1, meaning 1 = wrap 9999->0000 with sticky overflow, 0 = saturate at 9999 in HOLD.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pulse_1s, input, 1, one-cycle tick once per second.
REQ-006 SHALL have port pulse_fltr, input, 1, one-cycle button-sampling strobe.
REQ-007 SHALL have port btn_ss, input, 1, raw start/stop button, active-high, asynchronous to clk.
REQ-008 SHALL have port btn_clr, input, 1, raw clear button, active-high, asynchronous to clk.
REQ-009 SHALL have port dig_sel, input, 2, display digit currently scanned (0 = least significant).
REQ-010 SHALL have port dig_val, output, 4, BCD value of the selected digit.
REQ-011 SHALL have port dig_blank, output, 1, high when the selected digit is a leading zero.
REQ-012 SHALL have port running, output, 1, high in RUN.
REQ-013 SHALL have port ovf, output, 1, sticky wrap flag.
REQ-014 SHALL have port state, output, 2, FSM state code: IDLE=0, RUN=1, PAUSE=2, HOLD=3.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-016 SHALL sample each synchronized button only on cycles with pulse_fltr=1, and SHALL update the debounced level only after DEB_SAMPLES consecutive equal samples.
REQ-017 SHALL generate a one-cycle press event on each debounced 0->1 transition; release events are ignored.
REQ-018 SHALL implement these FSM transitions:
- IDLE + ss -> RUN
- RUN + ss -> PAUSE
- PAUSE + ss -> RUN
- PAUSE + clr -> IDLE
- HOLD + clr -> IDLE
- clr in IDLE or RUN is ignored.
- ss in HOLD is ignored.
REQ-019 SHALL give clr priority over ss in PAUSE and HOLD when both press events occur in the same cycle; in IDLE and RUN, ss is acted on.
REQ-020 SHALL hold a 4-digit BCD count, with each digit in 0..9 at all times.
REQ-021 SHALL increment the count by 1 on pulse_1s when the current (pre-transition) state is RUN, so a tick coincident with ss in RUN still counts.
REQ-022 SHALL, at count 9999 with WRAP_EN=1, wrap the increment to 0000 and set ovf in the same edge.
REQ-023 SHALL, at count 9999 with WRAP_EN=0, hold the count and transition RUN->HOLD.
REQ-024 SHALL make the entry into IDLE via clr zero the count and ovf on the same edge.
REQ-025 SHALL register dig_val and dig_blank from dig_sel and the count with exactly 1 cycle latency.
REQ-026 SHALL assert dig_blank for digit n>0 when digit n and all higher digits are 0; digit 0 is never blanked, so 0000 shows "   0".
REQ-027 SHALL make running, ovf and state registered outputs, valid the cycle after the transition edge.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state=IDLE, count=0000, ovf=0, running=0, dig_val=0, dig_blank=0, synchronizer and debounce flops to 0, and debounce counters to 0.
REQ-029 SHALL, on rst_n low mid-operation (any state, partial debounce), discard pending press events, with no event generated on the first cycle after reset release.

Structure
REQ-030 SHALL define state encodings, BCD digit width (4) and digit count (4) in the shared package stopwatch_pkg.
REQ-031 SHALL instantiate one sub-module, btn_debounce (synchronizer + debounce + rise-edge event, parameter DEB_SAMPLES), once per button.
REQ-032 SHALL keep the FSM, BCD counter and digit readout in stopwatch_ctrl; the target size is 150-300 lines total.

Verification
REQ-033 SHALL verify debounce: btn_ss toggles every strobe for 10 strobes, then held high for 3 strobes -> exactly one ss event, state IDLE->RUN.
REQ-034 SHALL verify counting: RUN with 12 pulse_1s ticks -> count 0012; reading dig_sel=0..3 gives dig_val 2,1,0,0 and dig_blank 0,0,1,1.
REQ-035 SHALL verify wrap: preload to 9998 via ticks, WRAP_EN=1, 2 ticks -> count 0000, ovf=1, state RUN; then ss, clr -> IDLE, ovf=0.
REQ-036 SHALL verify saturation: WRAP_EN=0 at 9999 with 1 tick -> state HOLD, count 9999; ss ignored; clr -> IDLE with count 0000.
REQ-037 SHALL verify simultaneous events: PAUSE with ss and clr events on the same cycle -> IDLE; RUN with pulse_1s and ss on the same cycle -> count+1 and PAUSE.
REQ-038 SHALL verify reset mid-run: count 0345 in RUN, rst_n pulsed low -> all outputs 0, state IDLE, and no spurious event with btn_ss held high across reset until DEB_SAMPLES strobes have elapsed.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state codes, BCD
// geometry and the BCD counter helpers.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HOLD  = 2'd3
    } sw_state_t;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_count_t;

    // Ripple a +1 through the BCD digits; 9999 rolls over to 0000.
    function automatic bcd_count_t bcd_inc(input bcd_count_t c);
        bcd_count_t r;
        logic       carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (c[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = c[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every digit is 9, i.e. the next increment overflows.
    function automatic logic bcd_is_max(input bcd_count_t c);
        logic m;
        m = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c[i] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, strobe-sampled debounce
// filter and a one-cycle event on each accepted press.
module btn_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic btn_raw,
    output logic press
);

    localparam logic [3:0] LAST_SAMPLE = 4'(DEB_SAMPLES - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [3:0] run_cnt;

    // Bring the asynchronous button into the clk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive strobe samples that disagree with the accepted
    // level; flip the level once enough agree, flagging a rising flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            run_cnt <= 4'd0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (strobe) begin
                if (sync2 != level) begin
                    if (run_cnt == LAST_SAMPLE) begin
                        level   <= sync2;
                        run_cnt <= 4'd0;
                        press   <= sync2;
                    end else begin
                        run_cnt <= run_cnt + 4'd1;
                    end
                end else begin
                    run_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and clear buttons drive a four-state
// FSM that gates a 4-digit BCD seconds counter; one digit at a time is
// presented to a scanned display with leading-zero blanking.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_SAMPLES = 3,
    parameter bit WRAP_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pulse_1s,
    input  logic       pulse_fltr,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic [1:0] dig_sel,
    output logic [3:0] dig_val,
    output logic       dig_blank,
    output logic       running,
    output logic       ovf,
    output logic [1:0] state
);

    logic       ss_evt;
    logic       clr_evt;
    sw_state_t  state_q;
    bcd_count_t count;
    logic       count_max;
    logic [3:0] digit_zero;
    logic [3:0] lead_zero;

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (pulse_fltr),
        .btn_raw(btn_ss),
        .press  (ss_evt)
    );

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (pulse_fltr),
        .btn_raw(btn_clr),
        .press  (clr_evt)
    );

    assign count_max = bcd_is_max(count);
    assign state     = state_q;

    // Control FSM together with the counter and overflow flag it owns;
    // the tick is judged against the pre-transition state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
            ovf     <= 1'b0;
            count   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_evt) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pulse_1s && count_max && !WRAP_EN) begin
                        // Saturated: freeze at 9999 and park in HOLD.
                        state_q <= ST_HOLD;
                        running <= 1'b0;
                    end else begin
                        if (pulse_1s) begin
                            count <= bcd_inc(count);
                            if (count_max) ovf <= 1'b1;
                        end
                        if (ss_evt) begin
                            state_q <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clr_evt) begin
                        state_q <= ST_IDLE;
                        count   <= '0;
                        ovf     <= 1'b0;
                    end else if (ss_evt) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (clr_evt) begin
                        state_q <= ST_IDLE;
                        count   <= '0;
                        ovf     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Per-digit zero flags and the leading-zero mask derived from them.
    // NOTE: every output of this combinational block is assigned on every
    // pass, so no latch is inferred.
    always_comb begin
        digit_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_zero[i] = (count[i] == 4'd0);
        end
        lead_zero[3] = digit_zero[3];
        lead_zero[2] = digit_zero[3] & digit_zero[2];
        lead_zero[1] = digit_zero[3] & digit_zero[2] & digit_zero[1];
        lead_zero[0] = 1'b0;
    end

    // Register the scanned digit and its blanking flag (one cycle latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_val   <= 4'd0;
            dig_blank <= 1'b0;
        end else begin
            dig_val   <= count[dig_sel];
            dig_blank <= lead_zero[dig_sel];
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one wrapping and one saturating
// instance share clock, ticks, strobes and digit select; each has its own
// buttons. Inputs change on the falling edge, outputs are sampled there too.
module tb_stopwatch_ctrl;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse_1s;
    logic       pulse_fltr;
    logic [1:0] btn_w;   // bit0 start/stop, bit1 clear
    logic [1:0] btn_s;
    logic [1:0] dig_sel;

    logic [3:0] dv_w, dv_s;
    logic       db_w, db_s, run_w, run_s, ovf_w, ovf_s;
    logic [1:0] st_w, st_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEB_SAMPLES(DEB), .WRAP_EN(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_1s  (pulse_1s),
        .pulse_fltr(pulse_fltr),
        .btn_ss    (btn_w[0]),
        .btn_clr   (btn_w[1]),
        .dig_sel   (dig_sel),
        .dig_val   (dv_w),
        .dig_blank (db_w),
        .running   (run_w),
        .ovf       (ovf_w),
        .state     (st_w)
    );

    stopwatch_ctrl #(.DEB_SAMPLES(DEB), .WRAP_EN(1'b0)) u_dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_1s  (pulse_1s),
        .pulse_fltr(pulse_fltr),
        .btn_ss    (btn_s[0]),
        .btn_clr   (btn_s[1]),
        .dig_sel   (dig_sel),
        .dig_val   (dv_s),
        .dig_blank (db_s),
        .running   (run_s),
        .ovf       (ovf_s),
        .state     (st_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle filter strobe; called and returns on a falling edge.
    task automatic strobe();
        pulse_fltr = 1'b1;
        @(negedge clk);
        pulse_fltr = 1'b0;
    endtask

    // Hold pulse_1s for n consecutive cycles: n increments while in RUN.
    task automatic ticks(input int n);
        pulse_1s = 1'b1;
        repeat (n) @(negedge clk);
        pulse_1s = 1'b0;
    endtask

    // Press the masked buttons long enough to debounce, optionally with a
    // tick on the cycle the FSM sees the event, then release cleanly.
    task automatic press(input bit sat, input logic [1:0] mask, input bit tick);
        if (sat) btn_s = mask; else btn_w = mask;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEB; i++) begin
            strobe();
            if (i < DEB - 1) @(negedge clk);
        end
        pulse_1s = tick;
        @(negedge clk);
        pulse_1s = 1'b0;
        if (sat) btn_s = 2'b00; else btn_w = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEB; i++) begin
            strobe();
            @(negedge clk);
        end
    endtask

    // Scan all four digits and assemble the BCD count.
    task automatic read_count(input bit sat, output logic [15:0] v);
        v = '0;
        for (int d = 0; d < 4; d++) begin
            dig_sel = 2'(d);
            @(negedge clk);
            v[d*4 +: 4] = sat ? dv_s : dv_w;
        end
    endtask

    logic [15:0] cnt;
    logic [3:0]  exp_val [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    logic        exp_blk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n      = 1'b0;
        pulse_1s   = 1'b0;
        pulse_fltr = 1'b0;
        btn_w      = 2'b00;
        btn_s      = 2'b00;
        dig_sel    = 2'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_state_w", 32'(st_w), 32'd0);
        check("rst_run_w", 32'(run_w), 32'd0);
        check("rst_ovf_w", 32'(ovf_w), 32'd0);
        check("rst_dval_w", 32'(dv_w), 32'd0);
        check("rst_dblank_w", 32'(db_w), 32'd0);
        check("rst_state_s", 32'(st_s), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(st_w), 32'd0);

        // Debounce: alternating samples never accepted
        for (int i = 0; i < 10; i++) begin
            btn_w[0] = (i % 2 == 0);
            repeat (3) @(negedge clk);
            strobe();
            @(negedge clk);
            check("bounce_idle", 32'(st_w), 32'd0);
        end
        btn_w[0] = 1'b1;
        repeat (3) @(negedge clk);
        strobe(); @(negedge clk);
        check("deb_after1", 32'(st_w), 32'd0);
        strobe(); @(negedge clk);
        check("deb_after2", 32'(st_w), 32'd0);
        strobe(); @(negedge clk);
        check("deb_run", 32'(st_w), 32'd1);
        check("deb_running", 32'(run_w), 32'd1);
        strobe(); @(negedge clk);
        strobe(); @(negedge clk);
        check("deb_single_evt", 32'(st_w), 32'd1);
        btn_w[0] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEB; i++) begin strobe(); @(negedge clk); end
        check("deb_release", 32'(st_w), 32'd1);

        // Counting and readout
        ticks(12);
        for (int d = 0; d < 4; d++) begin
            dig_sel = 2'(d);
            @(negedge clk);
            check($sformatf("dig_val%0d", d), 32'(dv_w), 32'(exp_val[d]));
            check($sformatf("dig_blank%0d", d), 32'(db_w), 32'(exp_blk[d]));
        end

        // Tick coincident with ss in RUN: counts and pauses
        press(1'b0, 2'b01, 1'b1);
        check("tick_ss_state", 32'(st_w), 32'd2);
        check("tick_ss_running", 32'(run_w), 32'd0);
        read_count(1'b0, cnt);
        check("tick_ss_count", 32'(cnt), 32'h0013);
        ticks(5);
        read_count(1'b0, cnt);
        check("pause_no_count", 32'(cnt), 32'h0013);

        // ss and clr together in PAUSE: clear wins
        press(1'b0, 2'b11, 1'b0);
        check("pause_both_state", 32'(st_w), 32'd0);
        read_count(1'b0, cnt);
        check("pause_both_count", 32'(cnt), 32'h0000);
        press(1'b0, 2'b10, 1'b0);
        check("idle_clr_ignored", 32'(st_w), 32'd0);

        // Wrap 9999 -> 0000 with sticky overflow
        press(1'b0, 2'b01, 1'b0);
        check("wrap_run", 32'(st_w), 32'd1);
        ticks(9998);
        read_count(1'b0, cnt);
        check("preload_9998", 32'(cnt), 32'h9998);
        check("preload_ovf", 32'(ovf_w), 32'd0);
        ticks(2);
        read_count(1'b0, cnt);
        check("wrap_count", 32'(cnt), 32'h0000);
        check("wrap_ovf", 32'(ovf_w), 32'd1);
        check("wrap_state", 32'(st_w), 32'd1);
        press(1'b0, 2'b01, 1'b0);
        check("wrap_pause", 32'(st_w), 32'd2);
        check("wrap_ovf_sticky", 32'(ovf_w), 32'd1);
        press(1'b0, 2'b10, 1'b0);
        check("wrap_clr_state", 32'(st_w), 32'd0);
        check("wrap_clr_ovf", 32'(ovf_w), 32'd0);

        // Saturating instance: 9999 + tick -> HOLD
        press(1'b1, 2'b01, 1'b0);
        check("sat_run", 32'(st_s), 32'd1);
        ticks(9999);
        read_count(1'b1, cnt);
        check("sat_9999", 32'(cnt), 32'h9999);
        check("sat_still_run", 32'(st_s), 32'd1);
        ticks(1);
        check("sat_hold", 32'(st_s), 32'd3);
        check("sat_running", 32'(run_s), 32'd0);
        check("sat_ovf", 32'(ovf_s), 32'd0);
        read_count(1'b1, cnt);
        check("sat_count_held", 32'(cnt), 32'h9999);
        press(1'b1, 2'b01, 1'b0);
        check("hold_ss_ignored", 32'(st_s), 32'd3);
        press(1'b1, 2'b10, 1'b0);
        check("hold_clr_state", 32'(st_s), 32'd0);
        read_count(1'b1, cnt);
        check("hold_clr_count", 32'(cnt), 32'h0000);
        check("wrap_inst_idle", 32'(st_w), 32'd0);

        // Reset mid-run with a partial debounce pending
        press(1'b0, 2'b01, 1'b0);
        ticks(345);
        read_count(1'b0, cnt);
        check("mid_count", 32'(cnt), 32'h0345);
        dig_sel = 2'd1;
        @(negedge clk);
        check("mid_dig1", 32'(dv_w), 32'd4);
        btn_w[0] = 1'b1;
        repeat (3) @(negedge clk);
        strobe(); @(negedge clk);
        strobe();
        rst_n = 1'b0;
        #1;
        check("mrst_state", 32'(st_w), 32'd0);
        check("mrst_running", 32'(run_w), 32'd0);
        check("mrst_ovf", 32'(ovf_w), 32'd0);
        check("mrst_dval", 32'(dv_w), 32'd0);
        check("mrst_dblank", 32'(db_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_first_cycle", 32'(st_w), 32'd0);
        @(negedge clk);
        strobe(); @(negedge clk);
        check("mrst_strobe1", 32'(st_w), 32'd0);
        strobe(); @(negedge clk);
        check("mrst_strobe2", 32'(st_w), 32'd0);
        strobe(); @(negedge clk);
        check("mrst_strobe3_run", 32'(st_w), 32'd1);
        read_count(1'b0, cnt);
        check("mrst_count", 32'(cnt), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
